// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with press/release debounce.
// Drives the rows one-cold (active-low) and samples the columns through a
// 2-flop synchronizer. A key becomes accepted after DEBOUNCE_CYCLES stable
// cycles. Acceptance updates key_code and raises key_held, and it fires a
// one-cycle key_valid pulse.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   column    keypad columns, active-low, asynchronous to clk
//   row       keypad row drive, one-cold active-low (registered)
//   key_code  hex code of the last accepted key
//   key_valid one-cycle pulse per accepted press (and per auto-repeat)
//   key_held  high while the accepted key stays pressed
//
// Optional feature macro: KEYPAD_REPEAT_EN. When it is defined, holding a key
// produces auto-repeat key_valid pulses. The first pulse comes REPEAT_DELAY
// cycles after acceptance, and later pulses come every REPEAT_RATE cycles.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] column,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state, n_state;
  logic [DW-1:0] div, n_div;
  logic [CW-1:0] cnt, n_cnt;
  logic [1:0]    row_idx, n_row_idx;
  logic [1:0]    col_idx, n_col_idx;
  logic [3:0]    col_m, col_s;
  logic [3:0]    n_row, n_code;
  logic          n_valid, n_held;
  logic          bit_up;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);
  logic [RW-1:0] rpt_cnt, n_rpt_cnt;
  logic          rpt_first, n_rpt_first;
`else
  logic unused_rpt_params;
  assign unused_rpt_params = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: keymap = 4'h1;  4'h1: keymap = 4'h2;  4'h2: keymap = 4'h3;  4'h3: keymap = 4'hA;
      4'h4: keymap = 4'h4;  4'h5: keymap = 4'h5;  4'h6: keymap = 4'h6;  4'h7: keymap = 4'hB;
      4'h8: keymap = 4'h7;  4'h9: keymap = 4'h8;  4'hA: keymap = 4'h9;  4'hB: keymap = 4'hC;
      4'hC: keymap = 4'hE;  4'hD: keymap = 4'h0;  4'hE: keymap = 4'hF;  default: keymap = 4'hD;
    endcase
  endfunction

  // Latched column reads 1 when that key is (momentarily) not pressed.
  assign bit_up = col_s[col_idx];

  always_comb begin
    n_state   = state;
    n_div     = div;
    n_cnt     = cnt;
    n_row_idx = row_idx;
    n_col_idx = col_idx;
    n_code    = key_code;
    n_valid   = 1'b0;
    n_held    = key_held;
`ifdef KEYPAD_REPEAT_EN
    n_rpt_cnt   = rpt_cnt;
    n_rpt_first = rpt_first;
`endif
    case (state)
      SCAN: begin
        if (div == DIV_LAST) begin
          n_div = '0;
          if (col_s != 4'hF) begin
            // Lowest-index low column wins among simultaneous keys on a row.
            if      (!col_s[0]) n_col_idx = 2'd0;
            else if (!col_s[1]) n_col_idx = 2'd1;
            else if (!col_s[2]) n_col_idx = 2'd2;
            else                n_col_idx = 2'd3;
            n_cnt   = '0;
            n_state = DEBOUNCE;
          end else begin
            n_row_idx = row_idx + 2'd1;
          end
        end else begin
          n_div = div + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (bit_up) begin
          n_state   = SCAN;
          n_row_idx = row_idx + 2'd1;
          n_div     = '0;
        end else if (cnt == CNT_LAST) begin
          n_code  = keymap(row_idx, col_idx);
          n_valid = 1'b1;
          n_held  = 1'b1;
          n_cnt   = '0;
          n_state = HELD;
`ifdef KEYPAD_REPEAT_EN
          n_rpt_cnt   = '0;
          n_rpt_first = 1'b1;
`endif
        end else begin
          n_cnt = cnt + CW'(1);
        end
      end
      HELD: begin
        if (bit_up) begin
          n_cnt   = '0;
          n_state = RELEASE;
`ifdef KEYPAD_REPEAT_EN
          n_rpt_cnt = '0;
`endif
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rpt_cnt == (rpt_first ? RD_LAST : RR_LAST)) begin
          n_valid     = 1'b1;
          n_rpt_cnt   = '0;
          n_rpt_first = 1'b0;
        end else begin
          n_rpt_cnt = rpt_cnt + RW'(1);
        end
`endif
      end
      RELEASE: begin
        if (!bit_up) begin
          n_state = HELD;
`ifdef KEYPAD_REPEAT_EN
          n_rpt_cnt   = '0;
          n_rpt_first = 1'b1;
`endif
        end else if (cnt == CNT_LAST) begin
          n_held    = 1'b0;
          n_state   = SCAN;
          n_row_idx = row_idx + 2'd1;
          n_div     = '0;
          n_cnt     = '0;
        end else begin
          n_cnt = cnt + CW'(1);
        end
      end
      default: n_state = SCAN;
    endcase
    n_row = ~(4'b0001 << n_row_idx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      div       <= '0;
      cnt       <= '0;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      col_m     <= 4'hF;
      col_s     <= 4'hF;
      row       <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= n_state;
      div       <= n_div;
      cnt       <= n_cnt;
      row_idx   <= n_row_idx;
      col_idx   <= n_col_idx;
      col_m     <= column;
      col_s     <= col_m;
      row       <= n_row;
      key_code  <= n_code;
      key_valid <= n_valid;
      key_held  <= n_held;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else begin
      rpt_cnt   <= n_rpt_cnt;
      rpt_first <= n_rpt_first;
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl (SCAN_DIV=4, DEBOUNCE_CYCLES=8).
// The keypad matrix is modelled from a 16-bit 'pressed' mask (bit r*4+c).
module tb_keypad_scan_ctrl;
  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] column;
  logic [3:0] row, key_code;
  logic       key_valid, key_held;
  logic [15:0] pressed = '0;

  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(20), .REPEAT_RATE(10)) dut (
    .clk(clk), .rst(rst), .column(column), .row(row),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    column = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) column[c] = 1'b0;
  end

  // Counts key_valid pulses; sampled before the edge updates key_valid.
  always @(posedge clk) if (key_valid) pulses <= pulses + 1;

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  code;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [15:0] k(input int r, input int c);
    logic [15:0] one = 16'd1;
    return one << (r*4 + c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0; pressed = '0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (key_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_held_low(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!key_held) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    bit ok;
    int mism, p0;
    logic exp_v;

    tbl[0] = '{k(0,0), 4'h1};
    tbl[1] = '{k(0,3), 4'hA};
    tbl[2] = '{k(1,2), 4'h6};
    tbl[3] = '{k(2,3), 4'hC};
    tbl[4] = '{k(3,0), 4'hE};
    tbl[5] = '{k(3,1), 4'h0};
    tbl[6] = '{k(3,3), 4'hD};
    tbl[7] = '{k(1,1), 4'h5};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_row", row, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);

    // Idle scan: each row for SD cycles, no pulses over 100 cycles
    @(posedge clk); #1 rst = 1'b1;
    mism = 0;
    for (int i = 0; i < 20; i++) begin
      logic [3:0] er;
      @(negedge clk);
      er = ~(4'b0001 << ((i / SD) % 4));
      if (row !== er) mism++;
    end
    chk("idle_row_sequence_mismatches", mism, 0);
    repeat (80) @(posedge clk);
    chk("idle_no_pulse", pulses, 0);

    // Key 8: exact latency and held-release timing
    do_reset();
    pressed = k(2,1);
    mism = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      exp_v = (i == 20);
      if (key_valid !== exp_v) mism++;
      if (i == 20) begin
        chk("k8_code", key_code, 4'h8);
        chk("k8_held", key_held, 1'b1);
        chk("k8_row_frozen", row, 4'b1011);
      end
    end
    chk("k8_valid_timing_mismatches", mism, 0);
    @(posedge clk); #1 pressed = '0;
    repeat (DB + 2) @(posedge clk);
    @(negedge clk); chk("k8_held_before_release_done", key_held, 1'b1);
    @(posedge clk);
    @(negedge clk); chk("k8_held_after_release", key_held, 1'b0);
    chk("k8_code_retained", key_code, 4'h8);

    // Table of single keys
    for (int t = 0; t < 8; t++) begin
      p0 = pulses;
      @(posedge clk); #1 pressed = tbl[t].mask;
      wait_valid(60, ok);
      chk($sformatf("tbl%0d_valid_seen", t), ok, 1'b1);
      chk($sformatf("tbl%0d_code", t), key_code, tbl[t].code);
      chk($sformatf("tbl%0d_held", t), key_held, 1'b1);
      repeat (8) @(posedge clk);
      #1 pressed = '0;
      wait_held_low(40, ok);
      chk($sformatf("tbl%0d_release_seen", t), ok, 1'b1);
      @(posedge clk);
      chk($sformatf("tbl%0d_pulse_count", t), pulses - p0, 1);
      chk($sformatf("tbl%0d_code_kept", t), key_code, tbl[t].code);
      repeat (2) @(posedge clk);
    end

    // Glitch on key * : DEBOUNCE is entered then abandoned
    do_reset();
    p0 = pulses;
    repeat (12) @(posedge clk);
    #1 pressed = k(3,0);
    repeat (3) @(posedge clk);
    #1 pressed = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); chk("glitch_row_frozen", row, 4'b0111);
    @(posedge clk);
    @(negedge clk); chk("glitch_row_resume", row, 4'b1110);
    repeat (40) @(posedge clk);
    chk("glitch_no_pulse", pulses - p0, 0);

    // # and D together: column 2 wins, row stays on row 3 while held
    p0 = pulses;
    @(posedge clk); #1 pressed = k(3,2) | k(3,3);
    wait_valid(60, ok);
    chk("dual_valid_seen", ok, 1'b1);
    chk("dual_code", key_code, 4'hF);
    mism = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (row !== 4'b0111) mism++;
    end
    chk("dual_row_frozen_mismatches", mism, 0);
    #1 pressed = '0;
    wait_held_low(40, ok);
    chk("dual_release_seen", ok, 1'b1);
    @(posedge clk);
    chk("dual_pulse_count", pulses - p0, 1);

    // Reset during DEBOUNCE (key 4, row 1)
    do_reset();
    pressed = k(1,0);
    repeat (10) @(posedge clk);
    @(negedge clk); chk("rstdb_row_frozen", row, 4'b1101);
    @(posedge clk); #1 rst = 1'b0; pressed = '0;
    #1;
    chk("rstdb_row", row, 4'b1110);
    chk("rstdb_valid", key_valid, 1'b0);
    chk("rstdb_held", key_held, 1'b0);
    p0 = pulses;
    @(posedge clk); #1 rst = 1'b1;
    repeat (40) @(posedge clk);
    chk("rstdb_no_pulse", pulses - p0, 0);

    // Reset during HELD
    #1 pressed = k(1,0);
    wait_valid(60, ok);
    chk("rsth_valid_seen", ok, 1'b1);
    chk("rsth_code_before", key_code, 4'h4);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("rsth_held", key_held, 1'b0);
    chk("rsth_code", key_code, 4'h0);
    chk("rsth_row", row, 4'b1110);
    pressed = '0;
    @(posedge clk); #1 rst = 1'b1;

    // Long hold of key 5: auto-repeat pattern (or a single pulse)
    do_reset();
    pressed = k(1,1);
    wait_valid(60, ok);
    chk("hold5_valid_seen", ok, 1'b1);
    chk("hold5_code", key_code, 4'h5);
    mism = 0;
    for (int i = 1; i <= 42; i++) begin
      @(negedge clk);
`ifdef KEYPAD_REPEAT_EN
      exp_v = (i == 20) || (i == 30) || (i == 40);
`else
      exp_v = 1'b0;
`endif
      if (key_valid !== exp_v) mism++;
      if (key_code !== 4'h5) mism++;
    end
    chk("hold5_repeat_pattern_mismatches", mism, 0);
    @(posedge clk); #1 pressed = '0;
    wait_held_low(40, ok);
    chk("hold5_release_seen", ok, 1'b1);
    @(posedge clk);
    p0 = pulses;
    repeat (30) @(posedge clk);
    chk("hold5_no_pulse_after_release", pulses - p0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
